// File: rtl/sevseg_pkg.sv
// Shared types and the active-low hex segment table for the seven-segment scan driver.
package sevseg_pkg;
  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active-low

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/sevseg_hex_decode.sv
// Nibble-to-segment decode; a blanked digit drives every segment off.
module sevseg_hex_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       seg
);
  assign seg = blank ? SEG_OFF : HEX_LUT[nibble];
endmodule

// File: rtl/sevseg_scan_driver.sv
// N-digit time-multiplexed seven-segment driver with a write-strobed value/blank register file.
// Optional SEVSEG_GHOST_BLANK_EN darkens the first BLANK_CYCLES of every dwell to hide PNP turn-off lag.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYCLES   = 30_000,
  parameter int BLANK_CYCLES   = 600,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  input  logic                          wr_blank,
  output seg_t                          seg,
  output logic [NUM_DIGITS-1:0]         sel,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  // Counter is sized to hold both the dwell and the blank threshold so the compare never truncates.
  localparam int CW = $clog2((DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? '1 : '0;

  logic [NUM_DIGITS-1:0][3:0] val_q;
  logic [NUM_DIGITS-1:0]      blank_q;
  logic [CW-1:0]              dwell_cnt;
  logic                       last_cnt, last_idx, drive;
  seg_t                       seg_d;
  logic [NUM_DIGITS-1:0]      sel_hot, sel_d;

  assign last_cnt = (dwell_cnt == CW'(DWELL_CYCLES - 1));
  assign last_idx = (digit_idx == IW'(NUM_DIGITS - 1));

`ifdef SEVSEG_GHOST_BLANK_EN
  assign drive = (dwell_cnt >= CW'(BLANK_CYCLES));
`else
  assign drive = 1'b1;
`endif

  sevseg_hex_decode u_dec (
    .nibble (val_q[digit_idx]),
    .blank  (blank_q[digit_idx] | ~drive),
    .seg    (seg_d)
  );

  assign sel_hot = drive ? (NUM_DIGITS'(1) << digit_idx) : '0;
  assign sel_d   = SEL_ACTIVE_LOW ? ~sel_hot : sel_hot;

  // Outputs register from the pre-edge index/regs, so any write or advance shows one edge later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dwell_cnt  <= '0;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
      seg        <= SEG_OFF;
      sel        <= SEL_OFF;
      val_q      <= '0;
      blank_q    <= '1;
    end else begin
      frame_tick <= 1'b0;
      if (last_cnt) begin
        dwell_cnt <= '0;
        if (last_idx) begin
          digit_idx  <= '0;
          frame_tick <= 1'b1;
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
      seg <= seg_d;
      sel <= sel_d;
      // Address decode by loop: addresses with no matching digit write nothing.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en && wr_addr == IW'(i)) begin
          val_q[i]   <= wr_data;
          blank_q[i] <= wr_blank;
        end
      end
    end
  end
endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Scoreboard bench: a time-based reference model pushes expected outputs each edge; a monitor pops and compares.
module tb_sevseg_scan_driver;
  localparam int D  = 4;
  localparam int B  = 1;
  localparam int NI = 2;
`ifdef SEVSEG_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  typedef struct {
    logic [6:0] seg;
    logic [3:0] sel;
    int         idx;
    bit         ft;
  } exp_t;

  logic       clk = 1'b0, reset = 1'b0, wr_en = 1'b0, wr_blank = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [6:0] seg0, seg1;
  logic [3:0] sel0;
  logic [2:0] sel1;
  logic [1:0] idx0, idx1;
  logic       ft0, ft1;

  sevseg_scan_driver #(.NUM_DIGITS(4), .DWELL_CYCLES(D), .BLANK_CYCLES(B), .SEL_ACTIVE_LOW(1'b1)) dut4 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_blank(wr_blank), .seg(seg0), .sel(sel0), .digit_idx(idx0), .frame_tick(ft0));

  sevseg_scan_driver #(.NUM_DIGITS(3), .DWELL_CYCLES(D), .BLANK_CYCLES(B), .SEL_ACTIVE_LOW(1'b1)) dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_blank(wr_blank), .seg(seg1), .sel(sel1), .digit_idx(idx1), .frame_tick(ft1));

  always #5 clk = ~clk;

  // Lit segments, active-high {g..a}; the display wants the complement.
  logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int         n_chk = 0, n_fail = 0;
  int         t [NI];
  logic [3:0] mv [NI][4];
  bit         mb [NI][4];
  exp_t       q0 [$], q1 [$];

  function automatic int nd(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  // Model: t edges since reset; index = (t/D)%n, frame every D*n edges; outputs lag the state by one edge.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      exp_t e;
      int n, pi, pc;
      bit on;
      logic [3:0] off;
      n   = nd(k);
      off = 4'((1 << n) - 1);
      if (!reset) begin
        t[k] = 0;
        for (int d = 0; d < 4; d++) begin mv[k][d] = 4'h0; mb[k][d] = 1'b1; end
        e.seg = 7'h7F; e.sel = off; e.idx = 0; e.ft = 1'b0;
      end else begin
        pi = (t[k] / D) % n;
        pc = t[k] % D;
        on = !(GHOST && pc < B);
        e.seg = (mb[k][pi] || !on) ? 7'h7F : ~seg_on[mv[k][pi]];
        e.sel = on ? 4'(off ^ (1 << pi)) : off;
        if (wr_en && int'(wr_addr) < n) begin
          mv[k][wr_addr] = wr_data;
          mb[k][wr_addr] = wr_blank;
        end
        t[k]  = t[k] + 1;
        e.idx = (t[k] / D) % n;
        e.ft  = (t[k] % (D * n) == 0);
      end
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("seg4", {1'b0, seg0}, {1'b0, e.seg});
      chk("sel4", {4'h0, sel0}, {4'h0, e.sel});
      chk("idx4", {6'h0, idx0}, 8'(e.idx));
      chk("ft4",  {7'h0, ft0},  {7'h0, e.ft});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("seg3", {1'b0, seg1}, {1'b0, e.seg});
      chk("sel3", {5'h0, sel1}, {4'h0, e.sel});
      chk("idx3", {6'h0, idx1}, 8'(e.idx));
      chk("ft3",  {7'h0, ft1},  {7'h0, e.ft});
    end
  end

  task automatic wr(input int a, input int d, input bit b);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = 4'(d); wr_blank = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) wr(i, i + 1, 1'b0);
    idle(32);
    idle(1);
    wr(int'(idx0), 4'hF, 1'b0);
    idle(6);
    wr(3, 4'h7, 1'b1);
    idle(20);
    wr(3, 4'h9, 1'b0);
    idle(12);
    for (int c = 0; c < 40 && idx0 != 2'd2; c++) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) wr(i, 4'hA + i, 1'b0);
    idle(20);
    repeat (800) begin
      reset    = ($urandom_range(99) != 0);
      wr_en    = ($urandom_range(3) == 0);
      wr_addr  = 2'($urandom_range(3));
      wr_data  = 4'($urandom_range(15));
      wr_blank = ($urandom_range(4) == 0);
      @(negedge clk);
    end
    reset = 1'b1;
    idle(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
